// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle for fetch_queue: 2-wide enqueue from fetch, 2-wide dequeue view and pop from decode.
// ADDR_W defaults to CPU_ADDR_BITS (32 if the build does not define it).
`ifndef CPU_ADDR_BITS
`define CPU_ADDR_BITS 32
`endif

interface fetch_queue_if #(
  parameter int ADDR_W = `CPU_ADDR_BITS,
  parameter int INST_W = 32
);
  logic [1:0]        enq_val;
  logic [ADDR_W-1:0] enq_pc0;
  logic [ADDR_W-1:0] enq_pc1;
  logic [INST_W-1:0] enq_inst0;
  logic [INST_W-1:0] enq_inst1;
  logic              enq_rdy;
  logic [1:0]        deq_val;
  logic [ADDR_W-1:0] deq_pc0;
  logic [ADDR_W-1:0] deq_pc1;
  logic [INST_W-1:0] deq_inst0;
  logic [INST_W-1:0] deq_inst1;
  logic [1:0]        deq_pop;

  modport master (
    output enq_val, enq_pc0, enq_pc1, enq_inst0, enq_inst1, deq_pop,
    input  enq_rdy, deq_val, deq_pc0, deq_pc1, deq_inst0, deq_inst1
  );

  modport slave (
    input  enq_val, enq_pc0, enq_pc1, enq_inst0, enq_inst1, deq_pop,
    output enq_rdy, deq_val, deq_pc0, deq_pc1, deq_inst0, deq_inst1
  );
endinterface

// File: rtl/fetch_queue.sv
// 2-in/2-out circular instruction queue decoupling fetch from decode, cleared by ROB flush.
// Optional macro FETCH_QUEUE_BYPASS_EN: same-cycle pass-through of accepted enqueues when empty.
`ifndef CPU_ADDR_BITS
`define CPU_ADDR_BITS 32
`endif

module fetch_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = `CPU_ADDR_BITS,
  parameter int INST_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  fetch_queue_if.slave             fq,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] RDY_MAX = CNT_W'(DEPTH - 2);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q, head1, tail1;
  logic [CNT_W-1:0]  count_q;
  logic [1:0]        push_n, pop_n;
  logic              enq_rdy;
  logic [1:0]        deq_val;
  logic [ADDR_W-1:0] deq_pc0, deq_pc1;
  logic [INST_W-1:0] deq_inst0, deq_inst1;

  always_comb begin
    enq_rdy = (count_q <= RDY_MAX);
    head1   = head_q + PTR_W'(1);
    tail1   = tail_q + PTR_W'(1);

    // Flush drops the enqueue outright; slot1 alone is never a push.
    push_n = 2'd0;
    if (!flush && enq_rdy && fq.enq_val[0])
      push_n = fq.enq_val[1] ? 2'd2 : 2'd1;

    deq_val   = {count_q >= CNT_W'(2), count_q >= CNT_W'(1)};
    deq_pc0   = pc_mem[head_q];
    deq_pc1   = pc_mem[head1];
    deq_inst0 = inst_mem[head_q];
    deq_inst1 = inst_mem[head1];
`ifdef FETCH_QUEUE_BYPASS_EN
    if (count_q == '0) begin
      deq_val   = {push_n == 2'd2, push_n != 2'd0};
      deq_pc0   = fq.enq_pc0;
      deq_pc1   = fq.enq_pc1;
      deq_inst0 = fq.enq_inst0;
      deq_inst1 = fq.enq_inst1;
    end
`endif

    // Pops beyond the presented valids are silently ignored.
    pop_n = 2'd0;
    if (!flush && fq.deq_pop[0] && deq_val[0])
      pop_n = (fq.deq_pop[1] && deq_val[1]) ? 2'd2 : 2'd1;
  end

  assign fq.enq_rdy   = enq_rdy;
  assign fq.deq_val   = deq_val;
  assign fq.deq_pc0   = deq_pc0;
  assign fq.deq_pc1   = deq_pc1;
  assign fq.deq_inst0 = deq_inst0;
  assign fq.deq_inst1 = deq_inst1;
  assign occupancy    = count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_n != 2'd0) begin
        pc_mem[tail_q]   <= fq.enq_pc0;
        inst_mem[tail_q] <= fq.enq_inst0;
      end
      if (push_n == 2'd2) begin
        pc_mem[tail1]   <= fq.enq_pc1;
        inst_mem[tail1] <= fq.enq_inst1;
      end
      tail_q  <= tail_q + PTR_W'(push_n);
      head_q  <= head_q + PTR_W'(pop_n);
      count_q <= count_q + CNT_W'(push_n) - CNT_W'(pop_n);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=8); covers both FETCH_QUEUE_BYPASS_EN builds.
module tb_fetch_queue;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [3:0] occupancy;
  int         n_cmp = 0;
  int         n_err = 0;

  fetch_queue_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) fq ();

  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .fq        (fq.slave),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] val, input logic [31:0] pc0, input logic [1:0] pop);
    fq.enq_val   = val;
    fq.enq_pc0   = pc0;
    fq.enq_pc1   = pc0 + 32'd4;
    fq.enq_inst0 = pc0 ^ 32'hA5A5_0000;
    fq.enq_inst1 = (pc0 + 32'd4) ^ 32'hA5A5_0000;
    fq.deq_pop   = pop;
  endtask

  initial begin
    drive(2'b11, 32'h100, 2'b00);
    // Reset held with enqueue requested
    #2 rst = 1'b0;
    #2;
    chk("rst_deq_val", fq.deq_val, 2'b00);
    chk("rst_enq_rdy", fq.enq_rdy, 1'b1);
    chk("rst_occ", occupancy, 0);
    chk("rst_deq_pc0", fq.deq_pc0, 0);
    tick;
    chk("rst_hold_occ", occupancy, 0);
    chk("rst_hold_val", fq.deq_val, 2'b00);
    #2 rst = 1'b1;

    // First push pair
    tick;
    drive(2'b00, 32'h0, 2'b00);
    chk("p1_val", fq.deq_val, 2'b11);
    chk("p1_pc0", fq.deq_pc0, 32'h100);
    chk("p1_pc1", fq.deq_pc1, 32'h104);
    chk("p1_inst0", fq.deq_inst0, 32'hA5A5_0100);
    chk("p1_inst1", fq.deq_inst1, 32'hA5A5_0104);
    chk("p1_occ", occupancy, 2);
    drive(2'b00, 32'h0, 2'b11);
    tick;
    drive(2'b00, 32'h0, 2'b00);
    chk("p1_drain_occ", occupancy, 0);
    chk("p1_drain_val", fq.deq_val, 2'b00);

    // Fill with pairs: 2,4,6,8; enq_rdy stays high through 6
    for (int k = 0; k < 4; k++) begin
      chk("fill_rdy", fq.enq_rdy, 1'b1);
      drive(2'b11, 32'h300 + 32'(8 * k), 2'b00);
      tick;
      chk("fill_occ", occupancy, 64'(2 * (k + 1)));
    end
    chk("full_rdy", fq.enq_rdy, 1'b0);
    drive(2'b11, 32'h900, 2'b00);
    tick;
    chk("full_push_ign", occupancy, 8);
    chk("full_pc0", fq.deq_pc0, 32'h300);
    for (int k = 0; k < 4; k++) begin
      chk("full_pop_pc0", fq.deq_pc0, 32'h300 + 32'(8 * k));
      chk("full_pop_pc1", fq.deq_pc1, 32'h304 + 32'(8 * k));
      drive(2'b00, 32'h0, 2'b11);
      tick;
    end
    chk("full_drained", occupancy, 0);

    // Single-slot fill to 7
    for (int k = 0; k < 7; k++) begin
      drive(2'b01, 32'h400 + 32'(4 * k), 2'b00);
      tick;
    end
    chk("single_occ7", occupancy, 7);
    chk("single_rdy7", fq.enq_rdy, 1'b0);
    drive(2'b11, 32'h900, 2'b00);
    tick;
    chk("occ7_push_ign", occupancy, 7);
    chk("occ7_pc0", fq.deq_pc0, 32'h400);
    drive(2'b00, 32'h0, 2'b11);
    tick;
    chk("occ5", occupancy, 5);
    chk("occ5_pc0", fq.deq_pc0, 32'h408);

    // Flush beats push and pop
    flush = 1'b1;
    drive(2'b11, 32'h900, 2'b11);
    tick;
    flush = 1'b0;
    drive(2'b00, 32'h0, 2'b00);
    chk("flush_occ", occupancy, 0);
    chk("flush_val", fq.deq_val, 2'b00);
    chk("flush_rdy", fq.enq_rdy, 1'b1);

    // enq_val=10 is not a push
    drive(2'b10, 32'h480, 2'b00);
    tick;
    chk("ev10_occ", occupancy, 0);
    chk("ev10_val", fq.deq_val, 2'b00);

    // Over-pop at occupancy 1
    drive(2'b01, 32'h500, 2'b00);
    tick;
    drive(2'b00, 32'h0, 2'b00);
    chk("one_occ", occupancy, 1);
    chk("one_val", fq.deq_val, 2'b01);
    drive(2'b00, 32'h0, 2'b11);
    tick;
    drive(2'b00, 32'h0, 2'b00);
    chk("overpop_occ", occupancy, 0);
    chk("overpop_val", fq.deq_val, 2'b00);
    drive(2'b01, 32'h504, 2'b00);
    tick;
    drive(2'b00, 32'h0, 2'b00);
    chk("overpop_head", fq.deq_pc0, 32'h504);
    drive(2'b00, 32'h0, 2'b01);
    tick;
    chk("overpop_drain", occupancy, 0);

    // Steady 2-in/2-out across pointer wrap
    drive(2'b11, 32'h600, 2'b00);
    tick;
    for (int i = 0; i < 10; i++) begin
      drive(2'b11, 32'h608 + 32'(8 * i), 2'b11);
      #1;
      chk("wrap_pc0", fq.deq_pc0, 32'h600 + 32'(8 * i));
      chk("wrap_pc1", fq.deq_pc1, 32'h604 + 32'(8 * i));
      tick;
      chk("wrap_occ", occupancy, 2);
    end
    drive(2'b00, 32'h0, 2'b11);
    tick;
    drive(2'b00, 32'h0, 2'b00);
    chk("wrap_drain", occupancy, 0);

    // Empty-queue push with same-cycle pop
    drive(2'b11, 32'h200, 2'b11);
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("byp_val", fq.deq_val, 2'b11);
    chk("byp_pc0", fq.deq_pc0, 32'h200);
    chk("byp_pc1", fq.deq_pc1, 32'h204);
    tick;
    drive(2'b00, 32'h0, 2'b00);
    chk("byp_occ", occupancy, 0);
    chk("byp_val_after", fq.deq_val, 2'b00);
`else
    chk("nobyp_val", fq.deq_val, 2'b00);
    tick;
    drive(2'b00, 32'h0, 2'b00);
    chk("nobyp_val_after", fq.deq_val, 2'b11);
    chk("nobyp_pc0", fq.deq_pc0, 32'h200);
    chk("nobyp_occ", occupancy, 2);
    drive(2'b00, 32'h0, 2'b11);
    tick;
    drive(2'b00, 32'h0, 2'b00);
`endif

    // Asynchronous reset mid-operation
    drive(2'b11, 32'h700, 2'b00);
    tick;
    chk("pre_rst_occ", occupancy, 2);
    drive(2'b11, 32'h710, 2'b01);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_val", fq.deq_val, 2'b00);
    chk("mid_rst_pc0", fq.deq_pc0, 0);
    chk("mid_rst_rdy", fq.enq_rdy, 1'b1);
    drive(2'b00, 32'h0, 2'b00);
    #2 rst = 1'b1;
    tick;
    chk("post_rst_occ", occupancy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
